// File: rtl/ime_mv_select_pkg.sv
// Types and helpers for ime_mv_select; partition codes come from enc_defines.
`ifndef ENC_DEFINES_V
`include "enc_defines.sv"
`endif

package ime_mv_select_pkg;

    localparam int MBT_W = `MB_TYPE_LEN;
    localparam int SBT_W = `SUB_MB_TYPE_LEN;

    localparam logic [MBT_W-1:0] P16X16 = `PART16X16;
    localparam logic [MBT_W-1:0] P16X8  = `PART16X8;
    localparam logic [MBT_W-1:0] P8X16  = `PART8X16;
    localparam logic [MBT_W-1:0] P8X8   = `PART8X8;

    localparam logic [SBT_W-1:0] SP8X8 = `SUBPART8X8;
    localparam logic [SBT_W-1:0] SP8X4 = `SUBPART8X4;
    localparam logic [SBT_W-1:0] SP4X8 = `SUBPART4X8;
    localparam logic [SBT_W-1:0] SP4X4 = `SUBPART4X4;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    // True when 4x4 block b is the first (z-order) block of its partition.
    function automatic logic is_lead(input logic [MBT_W-1:0] mbt,
                                     input logic [4*SBT_W-1:0] sub,
                                     input logic [3:0] b);
        logic [SBT_W-1:0] st;
        logic             r;
        st = sub[b[3:2]*SBT_W +: SBT_W];
        case (mbt)
            P16X8:   r = (b[2:0] == 3'd0);
            P8X16:   r = !b[3] && (b[1:0] == 2'd0);
            P8X8: begin
                case (st)
                    SP8X4:   r = !b[0];
                    SP4X8:   r = !b[1];
                    SP4X4:   r = 1'b1;
                    default: r = (b[1:0] == 2'd0);
                endcase
            end
            default: r = (b == 4'd0);
        endcase
        return r;
    endfunction

    // Index of the last leading block of the macroblock.
    function automatic logic [3:0] last_lead(input logic [MBT_W-1:0] mbt,
                                             input logic [4*SBT_W-1:0] sub);
        logic [3:0] r;
        case (mbt)
            P16X8:   r = 4'd8;
            P8X16:   r = 4'd4;
            P8X8: begin
                case (sub[3*SBT_W +: SBT_W])
                    SP8X4:   r = 4'd14;
                    SP4X8:   r = 4'd13;
                    SP4X4:   r = 4'd15;
                    default: r = 4'd12;
                endcase
            end
            default: r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enc_defines.sv
// Shared encoder partition codes and field widths, common to all encoder blocks.
`ifndef ENC_DEFINES_V
`define ENC_DEFINES_V

`define MB_TYPE_LEN      3
`define SUB_MB_TYPE_LEN  2

`define PART16X16  3'd0
`define PART16X8   3'd1
`define PART8X16   3'd2
`define PART8X8    3'd3

`define SUBPART8X8 2'd0
`define SUBPART8X4 2'd1
`define SUBPART4X8 2'd2
`define SUBPART4X4 2'd3

`endif

// File: rtl/ime_mv_mux.sv
// Combinational per-4x4-block MV selection from latched partition MVs.
module ime_mv_mux
    import ime_mv_select_pkg::*;
#(
    parameter int MV_W = 20
) (
    input  logic [MBT_W-1:0]   mb_type_i,
    input  logic [4*SBT_W-1:0] sub_mb_type_i,
    input  logic [3:0]         blk_i,
    input  logic [MV_W-1:0]    mv16x16_i,
    input  logic [2*MV_W-1:0]  mv16x8_i,
    input  logic [2*MV_W-1:0]  mv8x16_i,
    input  logic [4*MV_W-1:0]  mv8x8_i,
    input  logic [8*MV_W-1:0]  mv8x4_i,
    input  logic [8*MV_W-1:0]  mv4x8_i,
    input  logic [16*MV_W-1:0] mv4x4_i,
    output logic [MV_W-1:0]    mv_o
);

    logic [1:0]       q;
    logic [1:0]       s;
    logic [SBT_W-1:0] st;

    assign q  = blk_i[3:2];
    assign s  = blk_i[1:0];
    assign st = sub_mb_type_i[q*SBT_W +: SBT_W];

    always_comb begin
        mv_o = mv16x16_i;
        case (mb_type_i)
            P16X8:   mv_o = mv16x8_i[q[1]*MV_W +: MV_W];
            P8X16:   mv_o = mv8x16_i[q[0]*MV_W +: MV_W];
            P8X8: begin
                case (st)
                    SP8X4:   mv_o = mv8x4_i[{q, s[1]}*MV_W +: MV_W];
                    SP4X8:   mv_o = mv4x8_i[{q, s[0]}*MV_W +: MV_W];
                    SP4X4:   mv_o = mv4x4_i[blk_i*MV_W +: MV_W];
                    default: mv_o = mv8x8_i[q*MV_W +: MV_W];
                endcase
            end
            default: mv_o = mv16x16_i;
        endcase
    end

endmodule

// File: rtl/ime_mv_select.sv
// Streams the per-4x4 best MV of one macroblock as valid/ready beats in z-order.
// Optional macro IME_MVS_PART_EN: emit one beat per partition instead of 16.
module ime_mv_select
    import ime_mv_select_pkg::*;
#(
    parameter int MV_W = 20
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [MBT_W-1:0]     mb_type_i,
    input  logic [4*SBT_W-1:0]   sub_mb_type_i,
    input  logic [MV_W-1:0]      mv16x16_i,
    input  logic [2*MV_W-1:0]    mv16x8_i,
    input  logic [2*MV_W-1:0]    mv8x16_i,
    input  logic [4*MV_W-1:0]    mv8x8_i,
    input  logic [8*MV_W-1:0]    mv8x4_i,
    input  logic [8*MV_W-1:0]    mv4x8_i,
    input  logic [16*MV_W-1:0]   mv4x4_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [MV_W-1:0]      mv_o,
    output logic [3:0]           blk_idx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [MBT_W-1:0]     mbt_q;
    logic [4*SBT_W-1:0]   sub_q;
    logic [MV_W-1:0]      mv16x16_q;
    logic [2*MV_W-1:0]    mv16x8_q, mv8x16_q;
    logic [4*MV_W-1:0]    mv8x8_q;
    logic [8*MV_W-1:0]    mv8x4_q, mv4x8_q;
    logic [16*MV_W-1:0]   mv4x4_q;
    logic                 latch;
    logic                 lead;
    logic                 last;

    assign latch = (state_q == ST_IDLE) && start_i;

`ifdef IME_MVS_PART_EN
    assign lead = is_lead(mbt_q, sub_q, cnt_q);
    assign last = (cnt_q == last_lead(mbt_q, sub_q));
`else
    assign lead = 1'b1;
    assign last = (cnt_q == 4'd15);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mbt_q     <= '0;
            sub_q     <= '0;
            mv16x16_q <= '0;
            mv16x8_q  <= '0;
            mv8x16_q  <= '0;
            mv8x8_q   <= '0;
            mv8x4_q   <= '0;
            mv4x8_q   <= '0;
            mv4x4_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                mbt_q     <= mb_type_i;
                sub_q     <= sub_mb_type_i;
                mv16x16_q <= mv16x16_i;
                mv16x8_q  <= mv16x8_i;
                mv8x16_q  <= mv8x16_i;
                mv8x8_q   <= mv8x8_i;
                mv8x4_q   <= mv8x4_i;
                mv4x8_q   <= mv4x8_i;
                mv4x4_q   <= mv4x4_i;
            end
        end
    end

    // Non-leading blocks (partition mode only) advance without waiting on ready_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                busy_o  = 1'b1;
                valid_o = lead;
                if (!lead || ready_i) begin
                    if (last) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign blk_idx_o = cnt_q;

    ime_mv_mux #(.MV_W(MV_W)) u_mux (
        .mb_type_i     (mbt_q),
        .sub_mb_type_i (sub_q),
        .blk_i         (cnt_q),
        .mv16x16_i     (mv16x16_q),
        .mv16x8_i      (mv16x8_q),
        .mv8x16_i      (mv8x16_q),
        .mv8x8_i       (mv8x8_q),
        .mv8x4_i       (mv8x4_q),
        .mv4x8_i       (mv4x8_q),
        .mv4x4_i       (mv4x4_q),
        .mv_o          (mv_o)
    );

endmodule

// File: tb/tb_ime_mv_select.sv
// Randomised bench for ime_mv_select with a transaction-level beat-list model.
module tb_ime_mv_select;
    import ime_mv_select_pkg::*;

    localparam int MV_W = 20;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic                ready = 1'b1;
    logic [MBT_W-1:0]    mbt = '0;
    logic [4*SBT_W-1:0]  sub = '0;
    logic [MV_W-1:0]     v16x16 = '0;
    logic [2*MV_W-1:0]   v16x8 = '0, v8x16 = '0;
    logic [4*MV_W-1:0]   v8x8 = '0;
    logic [8*MV_W-1:0]   v8x4 = '0, v4x8 = '0;
    logic [16*MV_W-1:0]  v4x4 = '0;

    logic                valid_o, busy_o, done_o;
    logic [MV_W-1:0]     mv_o;
    logic [3:0]          blk_idx_o;

    int vectors = 0;
    int errors  = 0;

    ime_mv_select #(.MV_W(MV_W)) dut (
        .clk(clk), .rstn(rstn), .start_i(start),
        .mb_type_i(mbt), .sub_mb_type_i(sub),
        .mv16x16_i(v16x16), .mv16x8_i(v16x8), .mv8x16_i(v8x16),
        .mv8x8_i(v8x8), .mv8x4_i(v8x4), .mv4x8_i(v4x8), .mv4x4_i(v4x4),
        .ready_i(ready), .valid_o(valid_o), .mv_o(mv_o),
        .blk_idx_o(blk_idx_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              blk;
        logic [MV_W-1:0] mv;
    } beat_t;

    beat_t exp_q[$];

    // model snapshot taken when the model accepts a start
    logic [MBT_W-1:0]    m_mbt;
    logic [4*SBT_W-1:0]  m_sub;
    logic [MV_W-1:0]     m_16x16;
    logic [2*MV_W-1:0]   m_16x8, m_8x16;
    logic [4*MV_W-1:0]   m_8x8;
    logic [8*MV_W-1:0]   m_8x4, m_4x8;
    logic [16*MV_W-1:0]  m_4x4;
    int                  m_phase = 0;   // 0 idle, 1 sending, 2 done pulse
    int                  m_blk = 0;
    bit                  m_zero = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected beat list for one macroblock: every 4x4 block maps to one partition
    // (identified by a unique id) and that partition's MV.
    function automatic void build(input logic [MBT_W-1:0] t, input logic [4*SBT_W-1:0] sb,
                                  input logic [MV_W-1:0] a16x16, input logic [2*MV_W-1:0] a16x8,
                                  input logic [2*MV_W-1:0] a8x16, input logic [4*MV_W-1:0] a8x8,
                                  input logic [8*MV_W-1:0] a8x4, input logic [8*MV_W-1:0] a4x8,
                                  input logic [16*MV_W-1:0] a4x4);
        bit seen[int];
        exp_q.delete();
        for (int b = 0; b < 16; b++) begin
            int q, s, k, pid;
            logic [SBT_W-1:0] st;
            beat_t bt;
            q = b / 4;
            s = b % 4;
            bt.blk = b;
            if (t == P16X8) begin
                k = q / 2; pid = 100 + k; bt.mv = a16x8[k*MV_W +: MV_W];
            end else if (t == P8X16) begin
                k = q % 2; pid = 200 + k; bt.mv = a8x16[k*MV_W +: MV_W];
            end else if (t == P8X8) begin
                st = sb[q*SBT_W +: SBT_W];
                if (st == SP8X4) begin
                    k = 2*q + s/2; pid = 400 + k; bt.mv = a8x4[k*MV_W +: MV_W];
                end else if (st == SP4X8) begin
                    k = 2*q + s%2; pid = 500 + k; bt.mv = a4x8[k*MV_W +: MV_W];
                end else if (st == SP4X4) begin
                    k = b; pid = 600 + k; bt.mv = a4x4[k*MV_W +: MV_W];
                end else begin
                    k = q; pid = 300 + k; bt.mv = a8x8[k*MV_W +: MV_W];
                end
            end else begin
                pid = 0; bt.mv = a16x16;
            end
`ifdef IME_MVS_PART_EN
            if (!seen.exists(pid)) exp_q.push_back(bt);
`else
            exp_q.push_back(bt);
`endif
            seen[pid] = 1'b1;
        end
    endfunction

    // Compare then advance the model; inputs seen here are what the next edge samples.
    always @(negedge clk) begin
        bit ev;
        ev = (exp_q.size() > 0) && (exp_q[0].blk == m_blk);
        case (m_phase)
            0: begin
                chk("idle_valid", {31'd0, valid_o}, 32'd0);
                chk("idle_busy",  {31'd0, busy_o},  32'd0);
                chk("idle_done",  {31'd0, done_o},  32'd0);
                if (m_zero) begin
                    chk("rst_mv",  {12'd0, mv_o}, 32'd0);
                    chk("rst_blk", {28'd0, blk_idx_o}, 32'd0);
                end
            end
            1: begin
                chk("send_valid", {31'd0, valid_o}, {31'd0, ev});
                chk("send_busy",  {31'd0, busy_o},  32'd1);
                chk("send_done",  {31'd0, done_o},  32'd0);
                chk("send_blk",   {28'd0, blk_idx_o}, m_blk);
                if (ev) chk("send_mv", {12'd0, mv_o}, {12'd0, exp_q[0].mv});
            end
            default: begin
                chk("done_pulse", {31'd0, done_o},  32'd1);
                chk("done_busy",  {31'd0, busy_o},  32'd1);
                chk("done_valid", {31'd0, valid_o}, 32'd0);
            end
        endcase

        if (!rstn) begin
            m_phase = 0; m_blk = 0; m_zero = 1'b1; exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_mbt = mbt; m_sub = sub; m_16x16 = v16x16; m_16x8 = v16x8;
                    m_8x16 = v8x16; m_8x8 = v8x8; m_8x4 = v8x4; m_4x8 = v4x8; m_4x4 = v4x4;
                    build(m_mbt, m_sub, m_16x16, m_16x8, m_8x16, m_8x8, m_8x4, m_4x8, m_4x4);
                    m_blk = 0; m_phase = 1; m_zero = 1'b0;
                end
                1: begin
                    if (ev) begin
                        if (ready) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) m_phase = 2;
                            else m_blk++;
                        end
                    end else begin
                        m_blk++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 16; i++) v4x4[i*MV_W +: MV_W] = MV_W'($urandom);
        for (int i = 0; i < 8; i++) begin
            v8x4[i*MV_W +: MV_W] = MV_W'($urandom);
            v4x8[i*MV_W +: MV_W] = MV_W'($urandom);
        end
        for (int i = 0; i < 4; i++) v8x8[i*MV_W +: MV_W] = MV_W'($urandom);
        for (int i = 0; i < 2; i++) begin
            v16x8[i*MV_W +: MV_W] = MV_W'($urandom);
            v8x16[i*MV_W +: MV_W] = MV_W'($urandom);
        end
        v16x16 = MV_W'($urandom);
        sub    = (4*SBT_W)'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 400) begin tick(); n++; end
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_idle: busy_o still %0b, expected 0 within 400 cycles", busy_o);
        end
    endtask

    task automatic wait_blk(input int b);
        int n = 0;
        while (!(busy_o && blk_idx_o == 4'(b)) && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_blk: blk_idx_o %0d, expected %0d within 100 cycles", blk_idx_o, b);
        end
    endtask

    task automatic load_req031();
        for (int b = 0; b < 16; b++) v4x4[b*MV_W +: MV_W] = MV_W'(b);
        for (int k = 0; k < 8; k++) begin
            v8x4[k*MV_W +: MV_W] = MV_W'(100 + k);
            v4x8[k*MV_W +: MV_W] = MV_W'(200 + k);
        end
        for (int q = 0; q < 4; q++) v8x8[q*MV_W +: MV_W] = MV_W'(300 + q);
        mbt = P8X8;
        sub = {SP8X8, SP4X8, SP8X4, SP4X4};
    endtask

    initial begin
        int n;
        // Pin the model against hand-computed tables before the DUT is exercised.
        load_req031();
`ifndef IME_MVS_PART_EN
        begin
            int lit[16] = '{0, 1, 2, 3, 102, 102, 103, 103, 204, 205, 204, 205, 303, 303, 303, 303};
            build(mbt, sub, v16x16, v16x8, v8x16, v8x8, v8x4, v4x8, v4x4);
            chk("pin31_len", exp_q.size(), 16);
            for (int i = 0; i < 16 && i < exp_q.size(); i++)
                chk("pin31_mv", {12'd0, exp_q[i].mv}, lit[i]);
        end
`else
        v8x16 = {MV_W'(77), MV_W'(55)};
        build(P8X16, sub, v16x16, v16x8, v8x16, v8x8, v8x4, v4x8, v4x4);
        chk("pin35_len", exp_q.size(), 2);
        if (exp_q.size() == 2) begin
            chk("pin35_blk0", exp_q[0].blk, 0);
            chk("pin35_blk1", exp_q[1].blk, 4);
            chk("pin35_mv0", {12'd0, exp_q[0].mv}, 55);
            chk("pin35_mv1", {12'd0, exp_q[1].mv}, 77);
        end
`endif
        exp_q.delete();

        repeat (3) tick();
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        rstn = 1'b1;
        tick();

        // Whole-MB 16x16 with {x=3, y=-2}; done must appear 17 cycles after start.
        mbt = P16X16;
        v16x16 = {10'd3, 10'h3FE};
        ready = 1'b1;
        pulse_start();
        n = 1;
        while (!done_o && n < 40) begin tick(); n++; end
        chk("done_cycle", n, 17);
        tick();

        // Mixed sub-partitions.
        load_req031();
        pulse_start();
        wait_idle();
        tick();

        // 16x8 with a 5-cycle stall on block 6.
        rand_inputs();
        mbt = P16X8;
        pulse_start();
        wait_blk(6);
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        wait_idle();

        // Restart attempt mid-MB with new data must be ignored.
        rand_inputs();
        mbt = P8X8;
        pulse_start();
        wait_blk(4);
        rand_inputs();
        mbt = P16X16;
        pulse_start();
        wait_idle();

        // Reset at block 9, start held during reset, then a full fresh MB.
        rand_inputs();
        mbt = P8X8;
        pulse_start();
        wait_blk(9);
        rstn = 1'b0;
        start = 1'b1;
        tick();
        chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_mid_blk", {28'd0, blk_idx_o}, 32'd0);
        chk("rst_mid_mv", {12'd0, mv_o}, 32'd0);
        tick();
        start = 1'b0;
        rstn = 1'b1;
        tick();
        rand_inputs();
        mbt = P8X8;
        pulse_start();
        wait_idle();

        // Random macroblocks: random types (incl. unlisted codes), ready, stray starts.
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            mbt = MBT_W'($urandom_range(0, 7));
            ready = 1'($urandom_range(0, 1));
            pulse_start();
            n = 0;
            while (busy_o && n < 400) begin
                ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    rand_inputs();
                    mbt = MBT_W'($urandom_range(0, 7));
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                tick();
                n++;
            end
            start = 1'b0;
            if (n >= 400) begin
                errors++;
                $display("FAIL random_mb: busy_o still %0b, expected 0 within 400 cycles", busy_o);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ime_mv_select.md
IME_MV_SELECT -- requirements
Module: ime_mv_select

Interface
REQ-001 Parameter MV_W, default 20, packed MV width: {mvx[MV_W/2-1:0], mvy[MV_W/2-1:0]}, two's complement.
REQ-002 clk  input  1  clock, all logic on rising edge.
REQ-003 rstn  input  1  reset; synchronous, active-low.
REQ-004 start_i  input  1  one-cycle pulse: MB decision and all MV inputs valid this cycle.
REQ-005 mb_type_i  input  `MB_TYPE_LEN  MB partition (`PART16X16/`PART16X8/`PART8X16/`PART8X8).
REQ-006 sub_mb_type_i  input  4*`SUB_MB_TYPE_LEN  per-8x8 sub type, 8x8 index 0 in LSBs.
REQ-007 mv16x16_i 1*MV_W, mv16x8_i 2*MV_W, mv8x16_i 2*MV_W, mv8x8_i 4*MV_W, mv8x4_i 8*MV_W, mv4x8_i 8*MV_W, mv4x4_i 16*MV_W  inputs  best MV per partition, index 0 in LSBs.
REQ-008 valid_o  output  1  mv_o/blk_idx_o valid.
REQ-009 ready_i  input  1  consumer accepts beat.
REQ-010 mv_o  output  MV_W  selected MV.
REQ-011 blk_idx_o  output  4  4x4 block index, z-order: [3:2]=8x8 index q, [1:0]=sub index s (s[0]=x, s[1]=y).
REQ-012 busy_o  output  1  high from accepted start until done.
REQ-013 done_o  output  1  one-cycle pulse after last beat transferred.

Function
REQ-014 FSM states IDLE, SEND, DONE; IDLE->SEND on start_i; SEND->DONE on transfer of last beat; DONE->IDLE unconditionally after one cycle (done_o=1 in DONE).
REQ-015 On start_i in IDLE, all inputs latched into internal registers; later input changes have no effect on the current MB.
REQ-016 start_i in SEND or DONE ignored (no latch, no restart).
REQ-017 valid_o asserted first in the cycle after start_i; block counter starts at 0.
REQ-018 Transfer = valid_o && ready_i; counter increments by 1 per transfer; last block is 15 (no wrap to 0 within an MB).
REQ-019 While valid_o && !ready_i, mv_o and blk_idx_o held stable.
REQ-020 Selection for block b: PART16X16 -> mv16x16; PART16X8 -> mv16x8[q[1]]; PART8X16 -> mv8x16[q[0]]; PART8X8 -> per sub_mb_type[q]: SUBPART8X8 -> mv8x8[q], SUBPART8X4 -> mv8x4[2q+s[1]], SUBPART4X8 -> mv4x8[2q+s[0]], SUBPART4X4 -> mv4x4[b].
REQ-021 Unlisted mb_type code selects as PART16X16; unlisted sub type selects as SUBPART8X8.
REQ-022 Selection is a pure mux on latched data; mv_o is registered-input combinational, no arithmetic on MVs.
REQ-023 Minimum MB period 18 cycles (start, 16 beats with ready_i tied high, DONE); busy_o high throughout SEND and DONE.

Reset
REQ-024 rstn low at any edge, including mid-SEND: state IDLE, counter 0, valid_o=0, mv_o=0, blk_idx_o=0, busy_o=0, done_o=0, latched registers cleared; no residual beats after release.
REQ-025 start_i coincident with rstn low ignored.

Configuration
REQ-026 Macro IME_MVS_PART_EN defined: one beat per partition only; blocks that are not the first 4x4 of their partition consume one SEND cycle with valid_o=0 (counter advances without ready_i); last beat = last leading block, DONE follows its transfer.
REQ-027 Macro undefined: 16 beats always, per REQ-017..REQ-019.

Structure
REQ-028 Partition codes (`PART*, `SUBPART*), `MB_TYPE_LEN, `SUB_MB_TYPE_LEN come from shared enc_defines.v; none redefined locally; FSM state encodings local.
REQ-029 One sub-module ime_mv_mux: combinational per-block MV selection (REQ-020/021) from latched MVs, types and blk index.

Verification
REQ-030 PART16X16, mv16x16={x=3,y=-2}, ready_i=1 -> 16 beats blk 0..15 all {3,-2}, done_o at cycle 17 after start.
REQ-031 PART8X8, subs {4X4,8X4,4X8,8X8}, mv4x4[b]=b, mv8x4[k]=100+k, mv4x8[k]=200+k, mv8x8[q]=300+q -> blk0..3: 0,1,2,3; blk4..7: 102,102,103,103; blk8..11: 204,205,204,205; blk12..15: 303.
REQ-032 PART16X8 with ready_i low for 5 cycles at blk 6 -> beat 6 held stable, mv16x8[0] for blk0..7, mv16x8[1] for blk8..15, no beat lost/duplicated.
REQ-033 start_i pulsed again at blk 4 with different MVs -> ignored; current MB completes unchanged.
REQ-034 rstn low at blk 9 -> next cycle valid_o=0, all outputs 0; new start after release yields full 16 beats from blk 0.
REQ-035 IME_MVS_PART_EN, PART8X16 -> exactly 2 beats, blk_idx 0 then 4, mv8x16[0], mv8x16[1].
